// File: rtl/ascon_aead128_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ascon_aead128_pkg
// Description : Shared types and round constants for the Ascon-AEAD128
//               control path and data path.
// Revision    : 1.0 - initial release
// ============================================================================
package ascon_aead128_pkg;

  // Permutation round index; 12 rounds for p^a, the last 8 of them for p^b.
  typedef logic [3:0] round_t;

  // Controller phases: idle, key/nonce init, associated data, data, finalise.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_INIT = 3'd1,
    S_AD   = 3'd2,
    S_DB   = 3'd3,
    S_FIN  = 3'd4
  } state_t;

  localparam round_t ROUNDS_A_START = 4'd0;  // p^a: rounds 0..11
  localparam round_t ROUNDS_B_START = 4'd4;  // p^b: rounds 4..11
  localparam round_t LAST_ROUND     = 4'd11;

endpackage : ascon_aead128_pkg
`default_nettype wire

// File: rtl/control_path.sv
`default_nettype none
// ============================================================================
// Module      : control_path
// Description : Ascon-AEAD128 encryption sequencer. Counts permutation rounds,
//               handshakes AD and plaintext blocks at round boundaries and
//               drives the data path muxes, XOR enables and tag strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module control_path
  import ascon_aead128_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       new_key,
  input  logic       no_ad,
  input  logic       ad_valid,
  input  logic       ad_last,
  output logic       ad_ready,
  input  logic       db_valid,
  input  logic       db_last,
  output logic       db_ready,
  output logic       dout_valid,
  output logic       tag_valid,
  output logic       busy,
  output round_t     rnd,
  output logic       en_internal,
  output logic       en_new_key,
  output logic       sel_state,
  output logic       sel_din,
  output logic       sel_dout,
  output logic       sel_xor_data,
  output logic       end_ad,
  output logic [1:0] sel_xor_key
);

  state_t r_state;
  round_t r_cnt;
  logic   r_no_ad;
  logic   r_ad_done;

  state_t w_state_nxt;
  round_t w_cnt_nxt;
  logic   w_no_ad_nxt;
  logic   w_ad_done_nxt;

  // Boundary decisions: which block type is awaited and whether this is the
  // first absorption after initialisation (key XOR into s3:s4).
  logic w_from_init;
  logic w_want_ad;

  assign w_from_init = (r_state == S_INIT);
  assign w_want_ad   = (w_from_init && !r_no_ad) || ((r_state == S_AD) && !r_ad_done);

  // State, round counter and message flags; reset may hit mid-permutation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_no_ad   <= 1'b0;
      r_ad_done <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_no_ad   <= w_no_ad_nxt;
      r_ad_done <= w_ad_done_nxt;
    end
  end

  // Next-state and data path controls; defaults are the IDLE output values,
  // which also hold while reset is asserted.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_no_ad_nxt   = r_no_ad;
    w_ad_done_nxt = r_ad_done;
    ad_ready      = 1'b0;
    db_ready      = 1'b0;
    dout_valid    = 1'b0;
    tag_valid     = 1'b0;
    busy          = 1'b0;
    rnd           = '0;
    en_internal   = 1'b0;
    en_new_key    = 1'b0;
    sel_state     = 1'b1;
    sel_din       = 1'b0;
    sel_dout      = 1'b0;
    sel_xor_data  = 1'b0;
    end_ad        = 1'b0;
    sel_xor_key   = 2'b00;

    if (rst_n) begin
      case (r_state)
        S_IDLE: begin
          en_internal = start;
          en_new_key  = start & new_key;
          if (start) begin
            w_state_nxt   = S_INIT;
            w_cnt_nxt     = ROUNDS_A_START;
            w_no_ad_nxt   = no_ad;
            w_ad_done_nxt = 1'b0;
          end
        end

        S_INIT, S_AD, S_DB, S_FIN: begin
          busy      = 1'b1;
          sel_state = 1'b0;
          rnd       = r_cnt;
          if (r_cnt != LAST_ROUND) begin
            en_internal = 1'b1;
            w_cnt_nxt   = r_cnt + 4'd1;
          end else if (r_state == S_FIN) begin
            // Tag = s3:s4 ^ key, emitted without waiting.
            sel_xor_key = 2'b01;
            sel_dout    = 1'b1;
            tag_valid   = 1'b1;
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = ROUNDS_A_START;
          end else if (w_want_ad) begin
            // Hold at the boundary until an AD block arrives.
            ad_ready     = 1'b1;
            sel_xor_data = 1'b1;
            sel_xor_key  = w_from_init ? 2'b01 : 2'b00;
            if (ad_valid) begin
              en_internal   = 1'b1;
              w_ad_done_nxt = ad_last;
              w_cnt_nxt     = ROUNDS_B_START;
              w_state_nxt   = S_AD;
            end
          end else begin
            // Hold at the boundary until a plaintext block arrives. The first
            // DB after INIT/AD carries the domain separation bit.
            db_ready     = 1'b1;
            dout_valid   = 1'b1;
            sel_din      = 1'b1;
            sel_xor_data = 1'b1;
            end_ad       = (r_state != S_DB);
            sel_xor_key  = {db_last, w_from_init};
            if (db_valid) begin
              en_internal = 1'b1;
              if (db_last) begin
                w_state_nxt = S_FIN;
                w_cnt_nxt   = ROUNDS_A_START;
              end else begin
                w_state_nxt = S_DB;
                w_cnt_nxt   = ROUNDS_B_START;
              end
            end
          end
        end

        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

endmodule : control_path
`default_nettype wire

// File: tb/tb_control_path.sv
`default_nettype none
// ============================================================================
// Module      : tb_control_path
// Description : Directed, table-driven bench for control_path.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_control_path;

  typedef struct packed {
    logic rst_n;
    logic start;
    logic new_key;
    logic no_ad;
    logic ad_valid;
    logic ad_last;
    logic db_valid;
    logic db_last;
  } in_t;

  typedef struct packed {
    logic       busy;
    logic       ad_ready;
    logic       db_ready;
    logic       dout_valid;
    logic       tag_valid;
    logic       en_internal;
    logic       en_new_key;
    logic       sel_state;
    logic       sel_din;
    logic       sel_dout;
    logic       sel_xor_data;
    logic       end_ad;
    logic [1:0] sel_xor_key;
    logic [3:0] rnd;
  } out_t;

  typedef struct {
    int   reps;
    in_t  in;
    out_t exp;
    bit   inc;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n, start, new_key, no_ad, ad_valid, ad_last, db_valid, db_last;
  logic ad_ready, db_ready, dout_valid, tag_valid, busy;
  logic [3:0] rnd;
  logic en_internal, en_new_key, sel_state, sel_din, sel_dout, sel_xor_data, end_ad;
  logic [1:0] sel_xor_key;
  out_t act;

  int n_total = 0;
  int n_bad   = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  control_path u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .new_key(new_key), .no_ad(no_ad),
    .ad_valid(ad_valid), .ad_last(ad_last), .ad_ready(ad_ready),
    .db_valid(db_valid), .db_last(db_last), .db_ready(db_ready),
    .dout_valid(dout_valid), .tag_valid(tag_valid), .busy(busy), .rnd(rnd),
    .en_internal(en_internal), .en_new_key(en_new_key), .sel_state(sel_state),
    .sel_din(sel_din), .sel_dout(sel_dout), .sel_xor_data(sel_xor_data),
    .end_ad(end_ad), .sel_xor_key(sel_xor_key)
  );

  assign act = {busy, ad_ready, db_ready, dout_valid, tag_valid, en_internal,
                en_new_key, sel_state, sel_din, sel_dout, sel_xor_data, end_ad,
                sel_xor_key, rnd};

  function automatic in_t mk_in(bit r, bit s, bit nk, bit na, bit av, bit al, bit dv, bit dl);
    in_t i;
    i = {r, s, nk, na, av, al, dv, dl};
    return i;
  endfunction

  function automatic out_t e_idle(bit s, bit nk);
    out_t o = '0;
    o.sel_state = 1'b1; o.en_internal = s; o.en_new_key = s & nk;
    return o;
  endfunction

  function automatic out_t e_round(logic [3:0] r);
    out_t o = '0;
    o.busy = 1'b1; o.en_internal = 1'b1; o.rnd = r;
    return o;
  endfunction

  function automatic out_t e_ad(bit en, logic [1:0] key);
    out_t o = '0;
    o.busy = 1'b1; o.ad_ready = 1'b1; o.en_internal = en; o.sel_xor_data = 1'b1;
    o.sel_xor_key = key; o.rnd = 4'd11;
    return o;
  endfunction

  function automatic out_t e_db(bit en, bit ea, logic [1:0] key);
    out_t o = '0;
    o.busy = 1'b1; o.db_ready = 1'b1; o.dout_valid = 1'b1; o.en_internal = en;
    o.sel_din = 1'b1; o.sel_xor_data = 1'b1; o.end_ad = ea; o.sel_xor_key = key;
    o.rnd = 4'd11;
    return o;
  endfunction

  function automatic out_t e_tag();
    out_t o = '0;
    o.busy = 1'b1; o.tag_valid = 1'b1; o.sel_dout = 1'b1; o.sel_xor_key = 2'b01;
    o.rnd = 4'd11;
    return o;
  endfunction

  function automatic void add(int reps, in_t i, out_t e, bit inc);
    vec_t v;
    v.reps = reps; v.in = i; v.exp = e; v.inc = inc;
    tbl.push_back(v);
  endfunction

  function automatic void rounds(int n, logic [3:0] r0, in_t i);
    add(n, i, e_round(r0), 1'b1);
  endfunction

  task automatic apply(input in_t i);
    {rst_n, start, new_key, no_ad, ad_valid, ad_last, db_valid, db_last} = i;
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] a, input logic [31:0] e);
    n_total++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, a, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    in_t  ir, iq;
    out_t e;
    int   db_cyc, tag_cyc;

    iq = mk_in(1, 0, 0, 0, 0, 0, 0, 0);
    ir = mk_in(1, 0, 0, 0, 1, 0, 1, 0);

    // Reset, forced enables while rst_n low.
    add(2, mk_in(0, 1, 1, 0, 1, 1, 1, 1), e_idle(0, 0), 0);
    add(1, iq, e_idle(0, 0), 0);
    // 2 AD + 2 DB, valids always high.
    add(1, mk_in(1, 1, 1, 0, 1, 0, 1, 0), e_idle(1, 1), 0);
    rounds(11, 4'd0, ir);
    add(1, ir, e_ad(1, 2'b01), 0);
    rounds(7, 4'd4, ir);
    add(1, mk_in(1, 0, 0, 0, 1, 1, 1, 0), e_ad(1, 2'b00), 0);
    rounds(7, 4'd4, ir);
    add(1, ir, e_db(1, 1, 2'b00), 0);
    rounds(7, 4'd4, ir);
    add(1, mk_in(1, 0, 0, 0, 1, 0, 1, 1), e_db(1, 0, 2'b10), 0);
    rounds(11, 4'd0, ir);
    add(1, ir, e_tag(), 0);
    // Back-to-back, no AD, retained key; start held high while busy.
    add(1, mk_in(1, 1, 0, 1, 0, 0, 0, 0), e_idle(1, 0), 0);
    rounds(11, 4'd0, mk_in(1, 1, 1, 0, 0, 0, 1, 1));
    add(1, mk_in(1, 0, 0, 0, 0, 0, 1, 1), e_db(1, 1, 2'b11), 0);
    rounds(11, 4'd0, mk_in(1, 1, 1, 0, 1, 1, 1, 1));
    add(1, mk_in(1, 1, 1, 0, 0, 0, 0, 0), e_tag(), 0);
    add(1, iq, e_idle(0, 0), 0);
    // DB withheld 5 cycles at the boundary; stray ad_valid ignored.
    add(1, mk_in(1, 1, 1, 1, 0, 0, 0, 0), e_idle(1, 1), 0);
    rounds(11, 4'd0, iq);
    add(5, mk_in(1, 0, 0, 0, 1, 1, 0, 1), e_db(0, 1, 2'b11), 0);
    add(1, mk_in(1, 0, 0, 0, 0, 0, 1, 1), e_db(1, 1, 2'b11), 0);
    rounds(11, 4'd0, iq);
    add(1, iq, e_tag(), 0);
    add(1, iq, e_idle(0, 0), 0);
    // Reset during AD round 6.
    add(1, mk_in(1, 1, 1, 0, 0, 0, 0, 0), e_idle(1, 1), 0);
    rounds(11, 4'd0, iq);
    add(1, mk_in(1, 0, 0, 0, 1, 0, 0, 0), e_ad(1, 2'b01), 0);
    rounds(2, 4'd4, iq);
    add(1, mk_in(0, 1, 1, 0, 1, 0, 1, 0), e_idle(0, 0), 0);
    add(1, iq, e_idle(0, 0), 0);
    // Fresh message: AD withheld, one AD, DB withheld, two DB.
    add(1, mk_in(1, 1, 1, 0, 0, 0, 0, 0), e_idle(1, 1), 0);
    rounds(11, 4'd0, iq);
    add(2, mk_in(1, 0, 0, 0, 0, 1, 1, 1), e_ad(0, 2'b01), 0);
    add(1, mk_in(1, 0, 0, 0, 1, 1, 0, 0), e_ad(1, 2'b01), 0);
    rounds(7, 4'd4, iq);
    add(1, mk_in(1, 0, 0, 0, 1, 0, 0, 0), e_db(0, 1, 2'b00), 0);
    add(1, mk_in(1, 0, 0, 0, 0, 0, 1, 0), e_db(1, 1, 2'b00), 0);
    rounds(7, 4'd4, iq);
    add(1, mk_in(1, 0, 0, 0, 0, 0, 1, 1), e_db(1, 0, 2'b10), 0);
    rounds(11, 4'd0, iq);
    add(1, iq, e_tag(), 0);
    add(1, iq, e_idle(0, 0), 0);

    apply(mk_in(0, 0, 0, 0, 0, 0, 0, 0));
    tick();
    tick();

    for (int v = 0; v < tbl.size(); v++) begin
      for (int k = 0; k < tbl[v].reps; k++) begin
        apply(tbl[v].in);
        e = tbl[v].exp;
        if (tbl[v].inc) e.rnd = e.rnd + 4'(k);
        #1;
        check("vec", v, 32'(act), 32'(e));
        tick();
      end
    end

    // Latency: no-AD single-block message, measured from the start cycle.
    db_cyc  = -1;
    tag_cyc = -1;
    for (int c = 0; c < 64; c++) begin
      apply(mk_in(1, (c == 0), 0, 1, 0, 0, 1, 1));
      #1;
      if (dout_valid && db_cyc < 0) db_cyc = c;
      if (tag_valid) begin
        tag_cyc = c;
        tick();
        break;
      end
      tick();
    end
    check("db_latency", 0, 32'(db_cyc), 32'd12);
    check("tag_latency", 0, 32'(tag_cyc), 32'd24);
    apply(iq);
    #1;
    check("idle_after_tag", 0, 32'(act), 32'(e_idle(0, 0)));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule : tb_control_path
`default_nettype wire
